// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter with optional TX FIFO
//
// Serialises DATA_BITS-wide words as start, data (LSB first), optional parity
// and STOP_BITS stop bits. Each bit lasts CLKS_PER_BIT clocks. A word accepted
// in the last stop cycle starts the next frame with no idle gap.
// Optional macro UART_TX_FIFO_EN adds a FIFO_DEPTH-entry queue ahead of the
// serialiser.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high
//   tx_load  in   write strobe, accepted when tx_load && tx_ready
//   tx_data  in   word to send, captured on accept
//   tx_ready out  a word can be accepted this cycle
//   tx       out  registered serial line, idle high
//   tx_busy  out  a frame is on the line

module uart_tx_param #(
   parameter int CLKS_PER_BIT = 434,
   parameter int DATA_BITS    = 8,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tx_load,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_ready,
   output logic                 tx,
   output logic                 tx_busy
);

   localparam int            CW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
      $error("uart_tx_param: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_param: FIFO_DEPTH must be a power of 2 >= 2");
   end

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

   state_t               r_state, w_state_nxt;
   logic [CW-1:0]        r_baud;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift, w_shift_nxt, w_word;
   logic                 r_par, r_tx, r_run;
   logic                 w_tx_nxt, w_bit_done, w_last_stop, w_can_start, w_load;

   assign w_bit_done  = (r_baud == BAUD_LAST);
   assign w_last_stop = (r_state == S_STOP) && w_bit_done && (r_bit_cnt == STOP_LAST);
   // A new frame may begin from idle or straight out of the final stop cycle.
   assign w_can_start = (r_state == S_IDLE) || w_last_stop;

`ifdef UART_TX_FIFO_EN
   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
   logic [AW:0]          r_count;
   logic                 w_empty, w_full, w_push_req, w_push, w_pop;

   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == (AW+1)'(FIFO_DEPTH));
   assign tx_ready   = r_run && !w_full;
   assign w_push_req = tx_load && tx_ready;
   assign w_load     = w_can_start && (!w_empty || w_push_req);
   assign w_pop      = w_load && !w_empty;
   // An empty queue with a starting serialiser hands the word straight over.
   assign w_push     = w_push_req && !(w_empty && w_load);
   assign w_word     = w_empty ? tx_data : r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= tx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end
`else
   assign tx_ready = r_run && w_can_start;
   assign w_load   = tx_load && tx_ready;
   assign w_word   = tx_data;
`endif

   // State register and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_par     <= 1'b0;
         r_tx      <= 1'b1;
         r_run     <= 1'b0;
      end else begin
         // r_run holds tx_ready low until the first edge after reset releases.
         r_run   <= 1'b1;
         r_state <= w_state_nxt;
         r_shift <= w_shift_nxt;
         r_tx    <= w_tx_nxt;
         if (w_load) r_par <= (^w_word) ^ (PARITY == 1);
         if (r_state == S_IDLE || w_bit_done) r_baud <= '0;
         else                                 r_baud <= r_baud + 1'b1;
         // Shared counter: data bits in DATA, stop bits in STOP.
         if (w_state_nxt != r_state) r_bit_cnt <= '0;
         else if (w_bit_done)        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
   end

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_load) w_state_nxt = S_START;
         S_START: if (w_bit_done) w_state_nxt = S_DATA;
         S_DATA:  if (w_bit_done && r_bit_cnt == DATA_LAST)
                     w_state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
         S_PAR:   if (w_bit_done) w_state_nxt = S_STOP;
         S_STOP:  if (w_last_stop) w_state_nxt = w_load ? S_START : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic: tx is registered, so it is computed from the next state.
   always_comb begin
      w_shift_nxt = r_shift;
      if (w_load)                             w_shift_nxt = w_word;
      else if (r_state == S_DATA && w_bit_done) w_shift_nxt = r_shift >> 1;
      case (w_state_nxt)
         S_START: w_tx_nxt = 1'b0;
         S_DATA:  w_tx_nxt = w_shift_nxt[0];
         S_PAR:   w_tx_nxt = r_par;
         default: w_tx_nxt = 1'b1;
      endcase
   end

   assign tx      = r_tx;
   assign tx_busy = (r_state != S_IDLE);

endmodule
